alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one `alu` instance between two requesters (e.g. fetch/address unit and execute unit).
- Accepts an operation from the round-robin winner over a valid/ready handshake and registers the operands.
- Drives the ALU and holds its inputs stable for a programmable number of cycles.
- Captures result and compare flags, then returns them to the owning requester over a valid/ready response channel.
- One transaction in flight at a time.

Parameters:
- DATA_W, 8, operand width; ALU result is DATA_W+1 bits.
- OP_W, 3, op_code width.
- WAIT_CYCLES, 1, cycles ALU inputs are held before sampling result (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  arbiter accepts requester 0 op this cycle.
- req0_a, req0_b  in  DATA_W  operands.
- req0_op  in  OP_W  ALU op_code.
- rsp0_valid  out  1  result available for requester 0.
- rsp0_ready  in  1  requester 0 takes result.
- rsp0_result  out  DATA_W+1  captured ALU result.
- rsp0_flags  out  3  captured {gt,lt,eq}.
- req1_*/rsp1_*  same as requester 0.
- alu_a, alu_b  out  DATA_W  to ALU a, b.
- alu_op  out  OP_W  to ALU op_code.
- alu_result  in  DATA_W+1  from ALU result.
- alu_gt, alu_lt, alu_eq  in  1  from ALU flags.
- busy  out  1  state != IDLE.
- grant_id  out  1  owner of current/last transaction.

Behaviour:
- Clock and reset: clk is the single clock; rst_n is synchronous, active-low. All state is sampled on posedge clk; reset is applied when rst_n==0 at an edge.
- Reset values:
  - state=IDLE.
  - All rsp*_valid=0; rsp*_result=0; rsp*_flags=0.
  - alu_a=alu_b=0; alu_op=0.
  - grant_id=0; busy=0.
  - last_grant=1, so requester 0 wins the first conflict.
  - Wait counter=0.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE arbitration (combinational):
  - req0_ready = IDLE && (!req1_valid || last_grant==1).
  - req1_ready = IDLE && !req0_ready && req1_valid.
  - At most one ready high; ready is 0 outside IDLE.
- Accept (reqN_valid && reqN_ready at edge T):
  - Register a, b, op into alu_a/alu_b/alu_op.
  - grant_id=N; last_grant=N; counter=0; go EXEC.
- EXEC:
  - alu_* held stable; counter increments each cycle.
  - When counter==WAIT_CYCLES-1: capture alu_result/flags into the owner's rsp registers, set rspN_valid=1, go RESP.
  - Latency: rsp valid visible from cycle T+1+WAIT_CYCLES.
- RESP:
  - rspN_valid, result and flags held stable until rspN_ready.
  - On handshake: rspN_valid=0, go IDLE.
  - The next accept occurs no earlier than the cycle after the handshake.
  - Other requester's ready stays 0 throughout; response stall blocks the shared ALU by design.
- Non-owner rsp_valid is always 0; non-owner rsp_result/flags keep their previous values.
- alu_* outputs hold the last transaction's values while IDLE (no toggling).
- Width: result is passed through unmodified (9-bit incl. carry/borrow); no op decoding or filtering. Ops 6/7 return whatever the ALU gives (0).
- A requester may drop valid without a handshake; no effect, arbitration re-evaluates each cycle.
- Only one requester valid: it is served regardless of last_grant.
- Reset mid-operation (EXEC or RESP): transaction discarded, all outputs to reset values next edge, no response issued.

Test Plan:
- Single req0, a=200, b=100, op=000, rsp0_ready=1 -> req0_ready=1 at T; rsp0_valid at T+2; result=9'd300, flags=3'b100; busy high T+1..T+2.
- Both valid from reset, req0 op=001 (5-10), req1 op=010 (0xF0&0x3C):
  - req0 served first: result=9'h1FB, flags=3'b010.
  - req1 served next: result=9'h030.
  - Third simultaneous round grants req1 before req0 only if last_grant==0 (alternation check).
- Back-pressure: rsp0_ready low 5 cycles with req1_valid=1 -> rsp0_valid/result stable all 5 cycles, req1_ready=0; req1 accepted first cycle after rsp0 handshake.
- Reset mid-EXEC with WAIT_CYCLES=3 -> next cycle busy=0, rsp*_valid=0, alu_*=0; following req0 accepted immediately, valid after 4 cycles.
- Op 100 on a=0x81 -> result=9'h002; op 101 a=9, b=3 -> result=9'd1, flags=3'b100; op 111 -> result=0.
- Random mixed traffic, both requesters, random rsp_ready -> every accepted op answered exactly once, to the correct requester, in accept order, matching the alu golden model.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters, one op in flight.
// Response valid WAIT_CYCLES+1 cycles after accept; a stalled response holds off both requesters.
module alu_arbiter #(
  parameter int DATA_W      = 8,
  parameter int OP_W        = 3,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W:0]   rsp0_result,
  output logic [2:0]        rsp0_flags,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W:0]   rsp1_result,
  output logic [2:0]        rsp1_flags,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W:0]   alu_result,
  input  logic              alu_gt,
  input  logic              alu_lt,
  input  logic              alu_eq,
  output logic              busy,
  output logic              grant_id
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } op_t;

  typedef struct packed {
    logic [DATA_W:0] result;
    logic [2:0]      flags;
  } rsp_t;

  state_e           state_q, state_d;
  op_t              op_q, op_d;
  rsp_t             rsp0_q, rsp0_d, rsp1_q, rsp1_d;
  logic             rsp0_vld_q, rsp0_vld_d, rsp1_vld_q, rsp1_vld_d;
  logic             grant_q, grant_d, last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc0, acc1, exec_done, rsp_hs;

  assign acc0      = req0_valid && req0_ready;
  assign acc1      = req1_valid && req1_ready;
  assign exec_done = (state_q == EXEC) && (cnt_q == CNT_LAST);
  assign rsp_hs    = (state_q == RESP) &&
                     (grant_q ? (rsp1_vld_q && rsp1_ready) : (rsp0_vld_q && rsp0_ready));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc0 || acc1) state_d = EXEC;
      EXEC:    if (exec_done)    state_d = RESP;
      RESP:    if (rsp_hs)       state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // A lone valid requester wins; on conflict the one not granted last time wins.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == IDLE) begin
      req0_ready = req0_valid && (!req1_valid || last_q);
      req1_ready = req1_valid && !req0_ready;
    end
    busy = (state_q != IDLE);
  end

  always_comb begin
    op_d       = op_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    rsp0_d     = rsp0_q;
    rsp1_d     = rsp1_q;
    rsp0_vld_d = rsp0_vld_q;
    rsp1_vld_d = rsp1_vld_q;
    if (acc1) begin
      op_d.op = req1_op;
      op_d.a  = req1_a;
      op_d.b  = req1_b;
    end else if (acc0) begin
      op_d.op = req0_op;
      op_d.a  = req0_a;
      op_d.b  = req0_b;
    end
    if (acc0 || acc1) begin
      grant_d = acc1;
      last_d  = acc1;
      cnt_d   = '0;
    end
    if (state_q == EXEC) begin
      if (exec_done) begin
        if (grant_q) begin
          rsp1_d.result = alu_result;
          rsp1_d.flags  = {alu_gt, alu_lt, alu_eq};
          rsp1_vld_d    = 1'b1;
        end else begin
          rsp0_d.result = alu_result;
          rsp0_d.flags  = {alu_gt, alu_lt, alu_eq};
          rsp0_vld_d    = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (rsp_hs) begin
      rsp0_vld_d = 1'b0;
      rsp1_vld_d = 1'b0;
    end
  end

  // last_q resets to 1 so requester 0 wins the first conflict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q       <= '0;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      rsp0_q     <= '0;
      rsp1_q     <= '0;
      rsp0_vld_q <= 1'b0;
      rsp1_vld_q <= 1'b0;
    end else begin
      op_q       <= op_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      rsp0_q     <= rsp0_d;
      rsp1_q     <= rsp1_d;
      rsp0_vld_q <= rsp0_vld_d;
      rsp1_vld_q <= rsp1_vld_d;
    end
  end

  assign alu_a       = op_q.a;
  assign alu_b       = op_q.b;
  assign alu_op      = op_q.op;
  assign grant_id    = grant_q;
  assign rsp0_valid  = rsp0_vld_q;
  assign rsp0_result = rsp0_q.result;
  assign rsp0_flags  = rsp0_q.flags;
  assign rsp1_valid  = rsp1_vld_q;
  assign rsp1_result = rsp1_q.result;
  assign rsp1_flags  = rsp1_q.flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: instance 0 runs WAIT_CYCLES=1, instance 1 runs WAIT_CYCLES=3.
// A transaction-level model (accept time + hold time) is compared against both every cycle.
module tb_alu_arbiter;

  typedef struct packed {
    logic       rst_n, v0, v1, rr0, rr1;
    logic [7:0] a0, b0;
    logic [2:0] op0;
    logic [7:0] a1, b1;
    logic [2:0] op1;
  } in_t;

  typedef struct packed {
    logic       rdy0, rdy1, busy, gid, v0, v1;
    logic [8:0] res0;
    logic [2:0] f0;
    logic [8:0] res1;
    logic [2:0] f1;
    logic [7:0] a, b;
    logic [2:0] op;
  } obs_t;

  typedef struct {
    int          owner;
    logic [11:0] rf;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t  din  [2];
  obs_t dobs [2];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  // Golden ALU: {result[8:0], gt, lt, eq}
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
    logic [8:0] r;
    case (op)
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {1'b0, a} - {1'b0, b};
      3'd2:    r = {1'b0, a & b};
      3'd3:    r = {1'b0, a | b};
      3'd4:    r = {1'b0, a[6:0], 1'b0};
      3'd5:    r = {1'b0, a >> b[2:0]};
      default: r = 9'd0;
    endcase
    return {r, a > b, a < b, a == b};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    logic       r0, r1, bz, gid, v0, v1, gt, lt, eq;
    logic [8:0] res0, res1, ares;
    logic [2:0] f0, f1, aop;
    logic [7:0] aa, ab;

    alu_arbiter #(.DATA_W(8), .OP_W(3), .WAIT_CYCLES(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .rst_n(din[g].rst_n),
      .req0_valid(din[g].v0), .req0_ready(r0), .req0_a(din[g].a0), .req0_b(din[g].b0),
      .req0_op(din[g].op0), .rsp0_valid(v0), .rsp0_ready(din[g].rr0),
      .rsp0_result(res0), .rsp0_flags(f0),
      .req1_valid(din[g].v1), .req1_ready(r1), .req1_a(din[g].a1), .req1_b(din[g].b1),
      .req1_op(din[g].op1), .rsp1_valid(v1), .rsp1_ready(din[g].rr1),
      .rsp1_result(res1), .rsp1_flags(f1),
      .alu_a(aa), .alu_b(ab), .alu_op(aop), .alu_result(ares),
      .alu_gt(gt), .alu_lt(lt), .alu_eq(eq),
      .busy(bz), .grant_id(gid)
    );

    assign {ares, gt, lt, eq} = alu_ref(aa, ab, aop);
    assign dobs[g] = {r0, r1, bz, gid, v0, v1, res0, f0, res1, f1, aa, ab, aop};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model state: a transaction is in flight from its accept edge until its response handshake.
  bit          m_on   [2];
  bit          m_busy [2];
  int          m_own  [2];
  int          m_acc  [2];
  bit          m_last [2];
  bit          m_gid  [2];
  logic [11:0] m_gold [2];
  logic [11:0] m_rsp  [2][2];
  logic [7:0]  m_a    [2];
  logic [7:0]  m_b    [2];
  logic [2:0]  m_op   [2];
  sb_t         sbq    [2][$];
  int          cyc = 0;

  task automatic model_reset(input int i);
    m_busy[i]   = 1'b0;
    m_last[i]   = 1'b1;
    m_gid[i]    = 1'b0;
    m_a[i]      = '0;
    m_b[i]      = '0;
    m_op[i]     = '0;
    m_rsp[i][0] = '0;
    m_rsp[i][1] = '0;
    sbq[i].delete();
  endtask

  task automatic model_cycle(input int i);
    in_t  x;
    obs_t o;
    int   w;
    bit   e_r0, e_r1, e_vld;
    sb_t  s;
    x = din[i];
    o = dobs[i];
    w = (i == 0) ? 1 : 3;
    if (m_busy[i] && cyc == m_acc[i] + w) m_rsp[i][m_own[i]] = m_gold[i];
    e_vld = m_busy[i] && (cyc >= m_acc[i] + w);
    e_r0  = !m_busy[i] && x.v0 && (!x.v1 || m_last[i]);
    e_r1  = !m_busy[i] && x.v1 && !e_r0;
    if (m_on[i]) begin
      chk($sformatf("i%0d c%0d req0_ready", i, cyc), o.rdy0, e_r0);
      chk($sformatf("i%0d c%0d req1_ready", i, cyc), o.rdy1, e_r1);
      chk($sformatf("i%0d c%0d busy", i, cyc), o.busy, m_busy[i]);
      chk($sformatf("i%0d c%0d grant_id", i, cyc), o.gid, m_gid[i]);
      chk($sformatf("i%0d c%0d rsp0_valid", i, cyc), o.v0, e_vld && m_own[i] == 0);
      chk($sformatf("i%0d c%0d rsp1_valid", i, cyc), o.v1, e_vld && m_own[i] == 1);
      chk($sformatf("i%0d c%0d rsp0_data", i, cyc), {o.res0, o.f0}, m_rsp[i][0]);
      chk($sformatf("i%0d c%0d rsp1_data", i, cyc), {o.res1, o.f1}, m_rsp[i][1]);
      chk($sformatf("i%0d c%0d alu_in", i, cyc), {o.a, o.b, o.op}, {m_a[i], m_b[i], m_op[i]});
    end
    if (!x.rst_n) begin
      model_reset(i);
      m_on[i] = 1'b1;
    end else if (e_r0 || e_r1) begin
      m_own[i]  = e_r1 ? 1 : 0;
      m_busy[i] = 1'b1;
      m_acc[i]  = cyc + 1;
      m_last[i] = e_r1;
      m_gid[i]  = e_r1;
      m_a[i]    = e_r1 ? x.a1 : x.a0;
      m_b[i]    = e_r1 ? x.b1 : x.b0;
      m_op[i]   = e_r1 ? x.op1 : x.op0;
      m_gold[i] = alu_ref(m_a[i], m_b[i], m_op[i]);
      s.owner   = m_own[i];
      s.rf      = m_gold[i];
      sbq[i].push_back(s);
    end else if (e_vld && (m_own[i] == 1 ? x.rr1 : x.rr0)) begin
      m_busy[i] = 1'b0;
      s = sbq[i].pop_front();
      if (s.owner == 1) chk($sformatf("i%0d c%0d rsp_order", i, cyc), {2'b11, o.v1, o.res1, o.f1},
                            {1'b1, s.owner[0], 1'b1, s.rf});
      else              chk($sformatf("i%0d c%0d rsp_order", i, cyc), {2'b10, o.v0, o.res0, o.f0},
                            {1'b1, s.owner[0], 1'b1, s.rf});
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0);
    model_cycle(1);
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int i);
    din[i] = '0;
    tick();
    din[i].rst_n = 1'b1;
  endtask

  task automatic single(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [8:0] er, input logic [2:0] ef);
    din[0].v0  = 1'b1;
    din[0].a0  = a;
    din[0].b0  = b;
    din[0].op0 = op;
    din[0].rr0 = 1'b1;
    din[0].v1  = 1'b0;
    tick();
    din[0].v0 = 1'b0;
    tick();
    #2;
    chk($sformatf("op%0d valid", op), dobs[0].v0, 1'b1);
    chk($sformatf("op%0d result", op), dobs[0].res0, er);
    chk($sformatf("op%0d flags", op), dobs[0].f0, ef);
    tick();
  endtask

  initial begin
    din[0] = '0;
    din[1] = '0;
    tick();
    tick();
    din[0].rst_n = 1'b1;
    din[1].rst_n = 1'b1;
    #2;
    chk("reset busy", dobs[0].busy, 1'b0);
    chk("reset alu_in", {dobs[0].a, dobs[0].b, dobs[0].op}, 32'd0);
    chk("reset grant_id", dobs[0].gid, 1'b0);
    chk("reset rsp0", {dobs[0].v0, dobs[0].res0, dobs[0].f0}, 32'd0);

    // Single req0: 200+100
    tick();
    din[0].v0 = 1'b1; din[0].a0 = 8'd200; din[0].b0 = 8'd100; din[0].op0 = 3'd0;
    din[0].rr0 = 1'b1;
    #2; chk("t1 req0_ready T", dobs[0].rdy0, 1'b1);
    tick(); din[0].v0 = 1'b0;
    #2; chk("t1 busy T+1", dobs[0].busy, 1'b1); chk("t1 valid T+1", dobs[0].v0, 1'b0);
    tick(); #2;
    chk("t1 valid T+2", dobs[0].v0, 1'b1);
    chk("t1 result", dobs[0].res0, 9'd300);
    chk("t1 flags", dobs[0].f0, 3'b100);
    chk("t1 busy T+2", dobs[0].busy, 1'b1);
    tick(); #2;
    chk("t1 busy T+3", dobs[0].busy, 1'b0);
    chk("t1 valid T+3", dobs[0].v0, 1'b0);

    // Conflict from reset and alternation
    tick();
    do_reset(0);
    din[0].v0 = 1'b1; din[0].a0 = 8'd5; din[0].b0 = 8'd10; din[0].op0 = 3'd1;
    din[0].v1 = 1'b1; din[0].a1 = 8'hF0; din[0].b1 = 8'h3C; din[0].op1 = 3'd2;
    din[0].rr0 = 1'b1; din[0].rr1 = 1'b1;
    #2; chk("t2 r0 wins", {dobs[0].rdy0, dobs[0].rdy1}, 2'b10);
    tick(); din[0].v0 = 1'b0;
    tick(); #2;
    chk("t2 rsp0 valid", dobs[0].v0, 1'b1);
    chk("t2 rsp0 result", dobs[0].res0, 9'h1FB);
    chk("t2 rsp0 flags", dobs[0].f0, 3'b010);
    chk("t2 r1 held off", dobs[0].rdy1, 1'b0);
    tick(); #2; chk("t2 r1 ready", dobs[0].rdy1, 1'b1);
    tick(); din[0].v1 = 1'b0;
    tick(); #2;
    chk("t2 rsp1 valid", dobs[0].v1, 1'b1);
    chk("t2 rsp1 result", dobs[0].res1, 9'h030);
    chk("t2 rsp1 flags", dobs[0].f1, 3'b100);
    tick(); din[0].v0 = 1'b1; din[0].v1 = 1'b1;
    #2; chk("t2 third round r0 wins", {dobs[0].rdy0, dobs[0].rdy1}, 2'b10);
    tick(); din[0].v0 = 1'b0;
    tick();
    tick(); #2; chk("t2 third round r1 next", dobs[0].rdy1, 1'b1);
    tick(); din[0].v1 = 1'b0;
    tick();
    tick();

    // Back-pressure on rsp0 with req1 waiting
    do_reset(0);
    din[0].v0 = 1'b1; din[0].a0 = 8'd77; din[0].b0 = 8'd33; din[0].op0 = 3'd0;
    din[0].v1 = 1'b1; din[0].a1 = 8'd1; din[0].b1 = 8'd2; din[0].op1 = 3'd3;
    din[0].rr0 = 1'b0; din[0].rr1 = 1'b1;
    tick(); din[0].v0 = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      #2;
      chk($sformatf("t3 stall%0d rsp0", k), {dobs[0].v0, dobs[0].res0, dobs[0].f0},
          {1'b1, 9'd110, 3'b100});
      chk($sformatf("t3 stall%0d req1_ready", k), dobs[0].rdy1, 1'b0);
      tick();
    end
    din[0].rr0 = 1'b1;
    #2; chk("t3 hs cycle req1_ready", dobs[0].rdy1, 1'b0);
    tick(); #2; chk("t3 req1 accepted after hs", dobs[0].rdy1, 1'b1);
    tick(); din[0].v1 = 1'b0;
    tick();
    tick();

    // Op pass-through cases
    single(8'h81, 8'h00, 3'd4, 9'h002, 3'b100);
    single(8'd9, 8'd3, 3'd5, 9'd1, 3'b100);
    single(8'd7, 8'd7, 3'd7, 9'd0, 3'b001);

    // Reset mid-EXEC on the WAIT_CYCLES=3 instance
    din[1].v0 = 1'b1; din[1].a0 = 8'h55; din[1].b0 = 8'h12; din[1].op0 = 3'd0; din[1].rr0 = 1'b1;
    #2; chk("t4 req0_ready", dobs[1].rdy0, 1'b1);
    tick(); din[1].v0 = 1'b0;
    tick();
    din[1].rst_n = 1'b0;
    tick(); din[1].rst_n = 1'b1;
    #2;
    chk("t4 busy after reset", dobs[1].busy, 1'b0);
    chk("t4 rsp valid after reset", {dobs[1].v0, dobs[1].v1}, 2'b00);
    chk("t4 alu_in after reset", {dobs[1].a, dobs[1].b, dobs[1].op}, 32'd0);
    din[1].v0 = 1'b1;
    #1; chk("t4 req0 accepted at once", dobs[1].rdy0, 1'b1);
    tick(); din[1].v0 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #2; chk($sformatf("t4 no valid T+%0d", k), dobs[1].v0, 1'b0);
      tick();
    end
    #2;
    chk("t4 valid T+4", dobs[1].v0, 1'b1);
    chk("t4 result", dobs[1].res0, 9'h067);
    tick();

    // Random mixed traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        din[i].rst_n = ($urandom_range(0, 299) != 0);
        if ($urandom_range(0, 2) == 0) begin
          din[i].v0  = 1'($urandom_range(0, 1));
          din[i].a0  = 8'($urandom);
          din[i].b0  = 8'($urandom);
          din[i].op0 = 3'($urandom);
        end
        if ($urandom_range(0, 2) == 0) begin
          din[i].v1  = 1'($urandom_range(0, 1));
          din[i].a1  = 8'($urandom);
          din[i].b1  = 8'($urandom);
          din[i].op1 = 3'($urandom);
        end
        din[i].rr0 = ($urandom_range(0, 3) != 0);
        din[i].rr1 = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      din[i].rst_n = 1'b1;
      din[i].v0 = 1'b0; din[i].v1 = 1'b0;
      din[i].rr0 = 1'b1; din[i].rr1 = 1'b1;
    end
    repeat (10) tick();
    for (int i = 0; i < 2; i++)
      chk($sformatf("i%0d all answered", i), sbq[i].size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
